regfile_scoreboard: RTL
=======================

Name: regfile_scoreboard

Overview:
- Register-file end of the writeback interface for the 16-bit, 8-register pipelined core.
- Absorbs the writeback stage's address/write-enable/data triple and serves two combinational read ports to decode.
- Tracks in-flight destination writes per register with a pending-count scoreboard.
- Drives an issue-ready handshake so decode stalls on RAW hazards.

Parameters:
- DATA_W, 16, register width.
- ADDR_W, 3, register address width (2**ADDR_W registers).
- PEND_MAX, 3, max in-flight writes per register; counter width = clog2(PEND_MAX+1).

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  synchronous, active-high reset.
- wb_address  in  ADDR_W  writeback destination (from writeback stage address_out).
- wb_write_en  in  1  writeback commit strobe.
- wb_data  in  DATA_W  writeback value.
- rd_addr_a  in  ADDR_W  read port A address.
- rd_addr_b  in  ADDR_W  read port B address.
- rd_data_a  out  DATA_W  read port A data.
- rd_data_b  out  DATA_W  read port B data.
- issue_valid  in  1  decode presents an instruction.
- issue_use_a  in  1  instruction reads port A.
- issue_use_b  in  1  instruction reads port B.
- issue_dest  in  ADDR_W  destination of the issuing instruction.
- issue_write_en  in  1  issuing instruction writes issue_dest.
- issue_ready  out  1  instruction accepted this cycle when issue_valid && issue_ready.
- busy_mask  out  2**ADDR_W  bit i set when pend[i] != 0 (registered state).
- wb_underflow  out  1  sticky error: writeback to a register with pend == 0.

Behaviour:
- Reset (rst=1 at edge):
  - All registers = 0.
  - All pend = 0.
  - wb_underflow = 0.
  - busy_mask = 0.
  - Outputs valid the cycle after reset.
- R0 is hardwired zero:
  - Writes to R0 are discarded.
  - R0 never becomes pending.
  - Reads of R0 return 0.
- Write: on clk edge, if wb_write_en && wb_address != 0, then reg[wb_address] <= wb_data.
- Read: rd_data_x = reg[rd_addr_x], combinational from registered state (bypass per Optional Feature).
- Hazard for source x = issue_use_x && pend[rd_addr_x] != 0 && !bypass_hit_x.
- issue_ready = !(hazard_a || hazard_b || dest_full).
  - dest_full = issue_write_en && issue_dest != 0 && pend[issue_dest] == PEND_MAX.
  - issue_ready is combinational. It is valid regardless of issue_valid; it ignores hazards when the use bits are low.
- Accept = issue_valid && issue_ready.
  - On accept with issue_write_en && issue_dest != 0: inc[issue_dest].
- Writeback with wb_write_en && wb_address != 0: dec[wb_address].
- Per-register update at edge:
  - inc only: +1.
  - dec only: -1.
  - Both same cycle: unchanged.
  - dec at pend == 0: counter stays 0, wb_underflow <= 1 (sticky until rst).
  - inc && dec at pend == 0: counter becomes 1 via the unchanged rule? No: the net result is 0+1-1 = 0 → counter stays 0, no underflow flagged.
- Latency:
  - Write visible on read ports the cycle after the edge (without bypass).
  - Scoreboard change visible the cycle after the edge.
- No state machine beyond the per-register counters; counters saturate at 0 and PEND_MAX, no wrap.
- rst asserted mid-operation discards all pending counts; in-flight writebacks afterwards raise wb_underflow. The pipeline must be flushed together with rst.

Optional Feature:
- Macro: REGFILE_WB_BYPASS_EN.
- Defined:
  - rd_data_x = wb_data when wb_write_en && wb_address == rd_addr_x && rd_addr_x != 0.
  - bypass_hit_x is true in that case when pend[rd_addr_x] == 1, so a pending-by-one source issues in the writeback cycle.
- Undefined:
  - bypass_hit_x = 0.
  - Reads return registered state only.
  - Decode stalls until the cycle after writeback.

Decomposition:
- Shared package cpu_pkg:
  - DATA_W, ADDR_W, NUM_REGS constants.
  - reg_addr_t and word_t typedefs (reused by the writeback and decode stages).
- One natural sub-module: pend_counter.
  - One saturating up/down counter with inc, dec, underflow pulse and nonzero flag.
  - Instantiated per register 1..NUM_REGS-1.

Test Plan:
- Reset then read all → rd_data = 0x0000, busy_mask = 0x00, issue_ready = 1, wb_underflow = 0.
- Issue dest R3 (accept), next cycle issue_use_a rd_addr_a = 3 → issue_ready = 0, busy_mask = 0x08. Then wb R3 = 0xBEEF:
  - Bypass on: issue_ready = 1 in the wb cycle, rd_data_a = 0xBEEF.
  - Bypass off: issue_ready = 1 the following cycle.
- Three accepted issues to R5 then a fourth → issue_ready = 0 (dest_full). Then one wb R5 → pend[5] = 2, fourth issue accepted.
- Same-cycle accept of dest R2 and wb R2 while pend[2] = 1 → pend[2] stays 1, busy_mask[2] = 1, reg[2] updated.
- wb R4 with pend[4] = 0 → reg[4] written, wb_underflow = 1 and stays 1 until rst.
- wb R0 = 0x1234 and issue dest R0 → rd_data of R0 = 0, busy_mask[0] = 0, issue_ready = 1.

Source files
------------

// File: rtl/cpu_pkg.sv
// Shared core constants and register-file typedefs used by writeback, decode and the register file.
package cpu_pkg;

  localparam int unsigned DATA_W   = 16;
  localparam int unsigned ADDR_W   = 3;
  localparam int unsigned NUM_REGS = 2 ** ADDR_W;

  typedef logic [ADDR_W-1:0] reg_addr_t;
  typedef logic [DATA_W-1:0] word_t;

endpackage

// File: rtl/regfile_scoreboard_pend_counter.sv
// pend_counter: saturating up/down count of in-flight writes to one register.
module pend_counter #(
  parameter int unsigned PEND_MAX = 3,
  parameter int unsigned CNT_W    = $clog2(PEND_MAX + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             inc,
  input  logic             dec,
  output logic [CNT_W-1:0] count,
  output logic             nonzero,
  output logic             underflow_c
);

  // Simultaneous inc and dec cancel, including at zero.
  always_ff @(posedge clk) begin
    if (rst) begin
      count   <= '0;
      nonzero <= 1'b0;
    end else begin
      case ({inc, dec})
        2'b10: begin
          if (count != CNT_W'(PEND_MAX)) count <= count + CNT_W'(1);
          nonzero <= 1'b1;
        end
        2'b01: begin
          if (count != '0) count <= count - CNT_W'(1);
          nonzero <= (count > CNT_W'(1));
        end
        default: ;
      endcase
    end
  end

  assign underflow_c = dec && !inc && (count == '0);

endmodule

// File: rtl/regfile_scoreboard.sv
// 8x16 register file with two read ports and a per-register pending-write scoreboard for RAW stalls.
// Define REGFILE_WB_BYPASS_EN to forward the writeback value to the read ports and issue check.
module regfile_scoreboard
  import cpu_pkg::*;
#(
  parameter int unsigned PEND_MAX = 3
) (
  input  logic                clk,
  input  logic                rst,
  input  reg_addr_t           wb_address,
  input  logic                wb_write_en,
  input  word_t               wb_data,
  input  reg_addr_t           rd_addr_a,
  input  reg_addr_t           rd_addr_b,
  output word_t               rd_data_a,
  output word_t               rd_data_b,
  input  logic                issue_valid,
  input  logic                issue_use_a,
  input  logic                issue_use_b,
  input  reg_addr_t           issue_dest,
  input  logic                issue_write_en,
  output logic                issue_ready,
  output logic [NUM_REGS-1:0] busy_mask,
  output logic                wb_underflow
);

  localparam int unsigned CNT_W = $clog2(PEND_MAX + 1);

  word_t                          regs [NUM_REGS];
  logic [NUM_REGS-1:0][CNT_W-1:0] pend;
  logic [NUM_REGS-1:0]            inc_v, dec_v, nz_v, uf_v;
  logic                           wb_commit, accept, dest_full;
  logic                           hazard_a, hazard_b, hit_a, hit_b;
  word_t                          rf_a, rf_b;

  assign wb_commit = wb_write_en && (wb_address != '0);

  // Register storage; R0 is never written and reads as zero.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < int'(NUM_REGS); i++) regs[i] <= '0;
    end else if (wb_commit) begin
      regs[wb_address] <= wb_data;
    end
  end

  assign rf_a = (rd_addr_a == '0) ? '0 : regs[rd_addr_a];
  assign rf_b = (rd_addr_b == '0) ? '0 : regs[rd_addr_b];

`ifdef REGFILE_WB_BYPASS_EN
  logic byp_a, byp_b;
  assign byp_a     = wb_write_en && (wb_address == rd_addr_a) && (rd_addr_a != '0);
  assign byp_b     = wb_write_en && (wb_address == rd_addr_b) && (rd_addr_b != '0);
  assign rd_data_a = byp_a ? wb_data : rf_a;
  assign rd_data_b = byp_b ? wb_data : rf_b;
  assign hit_a     = byp_a && (pend[rd_addr_a] == CNT_W'(1));
  assign hit_b     = byp_b && (pend[rd_addr_b] == CNT_W'(1));
`else
  assign rd_data_a = rf_a;
  assign rd_data_b = rf_b;
  assign hit_a     = 1'b0;
  assign hit_b     = 1'b0;
`endif

  assign hazard_a    = issue_use_a && (pend[rd_addr_a] != '0) && !hit_a;
  assign hazard_b    = issue_use_b && (pend[rd_addr_b] != '0) && !hit_b;
  assign dest_full   = issue_write_en && (issue_dest != '0) &&
                       (pend[issue_dest] == CNT_W'(PEND_MAX));
  assign issue_ready = !(hazard_a || hazard_b || dest_full);
  assign accept      = issue_valid && issue_ready;

  // One-hot increment/decrement requests per register.
  always_comb begin
    inc_v = '0;
    dec_v = '0;
    if (accept && issue_write_en && (issue_dest != '0)) inc_v[issue_dest] = 1'b1;
    if (wb_commit) dec_v[wb_address] = 1'b1;
  end

  assign pend[0] = '0;
  assign nz_v[0] = 1'b0;
  assign uf_v[0] = 1'b0;

  for (genvar i = 1; i < int'(NUM_REGS); i++) begin : g_pend
    pend_counter #(.PEND_MAX(PEND_MAX), .CNT_W(CNT_W)) u_cnt (
      .clk        (clk),
      .rst        (rst),
      .inc        (inc_v[i]),
      .dec        (dec_v[i]),
      .count      (pend[i]),
      .nonzero    (nz_v[i]),
      .underflow_c(uf_v[i])
    );
  end

  assign busy_mask = nz_v;

  // Sticky underflow flag, cleared only by reset.
  always_ff @(posedge clk) begin
    if (rst) wb_underflow <= 1'b0;
    else if (|uf_v) wb_underflow <= 1'b1;
  end

endmodule
